// File: rtl/xgmii_xbar.sv
// rtl/xgmii_xbar.sv - XGMII crossbar with frame-boundary source switching
module xgmii_xbar #(
    parameter int                     NPORT       = 4,
    parameter int                     SEL_W       = 2,
    parameter logic [NPORT*SEL_W-1:0] DEFAULT_MAP = 8'h41
) (
    input  logic                   clk156,
    input  logic                   sys_rst_n,
    input  logic [NPORT*64-1:0]    rx_d,
    input  logic [NPORT*8-1:0]     rx_c,
    output logic [NPORT*64-1:0]    tx_d,
    output logic [NPORT*8-1:0]     tx_c,
    input  logic                   cfg_wr,
    input  logic [SEL_W-1:0]       cfg_port,
    input  logic [SEL_W-1:0]       cfg_src,
    output logic [NPORT*SEL_W-1:0] sel_active,
    output logic [NPORT-1:0]       sel_pending
);

    localparam logic [63:0] IDLE_D   = 64'h0707_0707_0707_0707;
    localparam logic [7:0]  IDLE_C   = 8'hFF;
    localparam logic [7:0]  CH_START = 8'hFB;
    localparam logic [7:0]  CH_TERM  = 8'hFD;

    logic [NPORT-1:0]       in_frame_q, in_frame_d;
    logic [NPORT-1:0]       has_start;
    logic [NPORT*SEL_W-1:0] sel_q, sel_d;
    logic [NPORT*SEL_W-1:0] pend_src_q, pend_src_d;
    logic [NPORT-1:0]       pend_q, pend_d;
    logic [NPORT*64-1:0]    tx_d_q, tx_d_d;
    logic [NPORT*8-1:0]     tx_c_q, tx_c_d;
    logic                   cfg_ok;

    // Frame trackers: lanes are walked in order so the last delimiter in the word decides the state.
    always_comb begin
        in_frame_d = in_frame_q;
        has_start  = '0;
        for (int i = 0; i < NPORT; i++) begin
            for (int k = 0; k < 8; k++) begin
                if (rx_c[8*i+k] && (rx_d[64*i+8*k +: 8] == CH_START) && (k == 0 || k == 4)) begin
                    in_frame_d[i] = 1'b1;
                    has_start[i]  = 1'b1;
                end
                if (rx_c[8*i+k] && (rx_d[64*i+8*k +: 8] == CH_TERM)) begin
                    in_frame_d[i] = 1'b0;
                end
            end
        end
    end

    // Per-output switch decision, then the config write judged against the post-switch mapping, then the data mux.
    always_comb begin
        logic [SEL_W-1:0] cur;
        logic [SEL_W-1:0] req;
        cur        = '0;
        req        = '0;
        sel_d      = sel_q;
        pend_src_d = pend_src_q;
        pend_d     = pend_q;
        tx_d_d     = '0;
        tx_c_d     = '0;
        cfg_ok     = cfg_wr && (int'(cfg_port) < NPORT) && (int'(cfg_src) < NPORT);
        for (int o = 0; o < NPORT; o++) begin
            cur = sel_q[SEL_W*o +: SEL_W];
            req = pend_src_q[SEL_W*o +: SEL_W];
            // Old source must be between frames and not starting one; new source may start this very word.
            if (pend_q[o] && !in_frame_q[cur] && !has_start[cur] && !in_frame_q[req]) begin
                sel_d[SEL_W*o +: SEL_W] = req;
                pend_d[o]               = 1'b0;
            end
            if (cfg_ok && (int'(cfg_port) == o)) begin
                if (cfg_src == sel_d[SEL_W*o +: SEL_W]) begin
                    pend_d[o] = 1'b0;
                end else begin
                    pend_src_d[SEL_W*o +: SEL_W] = cfg_src;
                    pend_d[o]                    = 1'b1;
                end
            end
            tx_d_d[64*o +: 64] = rx_d[64*int'(sel_d[SEL_W*o +: SEL_W]) +: 64];
            tx_c_d[8*o +: 8]   = rx_c[8*int'(sel_d[SEL_W*o +: SEL_W]) +: 8];
        end
    end

    // State registers; reset drives idle onto every TX port without waiting for a clock.
    always_ff @(posedge clk156 or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_d_q     <= {NPORT{IDLE_D}};
            tx_c_q     <= {NPORT{IDLE_C}};
            sel_q      <= DEFAULT_MAP;
            pend_src_q <= '0;
            pend_q     <= '0;
            in_frame_q <= '0;
        end else begin
            tx_d_q     <= tx_d_d;
            tx_c_q     <= tx_c_d;
            sel_q      <= sel_d;
            pend_src_q <= pend_src_d;
            pend_q     <= pend_d;
            in_frame_q <= in_frame_d;
        end
    end

    assign tx_d        = tx_d_q;
    assign tx_c        = tx_c_q;
    assign sel_active  = sel_q;
    assign sel_pending = pend_q;

endmodule

// File: tb/tb_xgmii_xbar.sv
// tb/tb_xgmii_xbar.sv - scoreboard testbench for xgmii_xbar
module tb_xgmii_xbar;

    localparam int NP = 4;
    localparam int SW = 3;
    localparam logic [NP*SW-1:0] DMAP = 12'h201;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NP*64-1:0]   rx_d;
    logic [NP*8-1:0]    rx_c;
    logic [NP*64-1:0]   tx_d;
    logic [NP*8-1:0]    tx_c;
    logic               cfg_wr;
    logic [SW-1:0]      cfg_port;
    logic [SW-1:0]      cfg_src;
    logic [NP*SW-1:0]   sel_active;
    logic [NP-1:0]      sel_pending;

    always #5 clk = ~clk;

    xgmii_xbar #(.NPORT(NP), .SEL_W(SW), .DEFAULT_MAP(DMAP)) dut (
        .clk156(clk), .sys_rst_n(rst_n), .rx_d(rx_d), .rx_c(rx_c),
        .tx_d(tx_d), .tx_c(tx_c), .cfg_wr(cfg_wr), .cfg_port(cfg_port),
        .cfg_src(cfg_src), .sel_active(sel_active), .sel_pending(sel_pending)
    );

    typedef struct {
        logic [NP*64-1:0] d;
        logic [NP*8-1:0]  c;
        logic [NP*SW-1:0] sel;
        logic [NP-1:0]    pend;
    } exp_t;

    exp_t sbq[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Word presented on each RX port this cycle, and what the generator knows about it.
    logic [63:0] w_d[NP];
    logic [7:0]  w_c[NP];
    bit          w_start[NP];
    bit          open[NP];
    int          rem[NP];

    // Reference model: mapping, pending requests, frame-open state seen by the crossbar.
    int  m_act[NP];
    int  m_psrc[NP];
    bit  m_pend[NP];
    bit  m_inf[NP];
    int  reset_map[NP] = '{1, 0, 0, 1};

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic put_idle(input int i);
        w_d[i] = 64'h0707_0707_0707_0707;
        w_c[i] = 8'hFF;
        w_start[i] = 1'b0;
        open[i] = 1'b0;
    endtask

    task automatic put_start(input int i, input bit hi);
        logic [63:0] r;
        r = {$urandom, $urandom};
        if (!hi) begin
            w_d[i] = {r[63:8], 8'hFB};
            w_c[i] = 8'h01;
        end else begin
            w_d[i] = {r[63:40], 8'hFB, 32'h0707_0707};
            w_c[i] = 8'h1F;
        end
        w_start[i] = 1'b1;
        open[i] = 1'b1;
    endtask

    task automatic put_data(input int i);
        w_d[i] = {$urandom, $urandom};
        w_c[i] = 8'h00;
        w_start[i] = 1'b0;
        open[i] = 1'b1;
    endtask

    task automatic put_term(input int i, input int lane, input bit restart);
        for (int k = 0; k < 8; k++) begin
            if (k < lane) begin
                w_d[i][8*k +: 8] = 8'($urandom);
                w_c[i][k] = 1'b0;
            end else if (k == lane) begin
                w_d[i][8*k +: 8] = 8'hFD;
                w_c[i][k] = 1'b1;
            end else if (restart && k == 4) begin
                w_d[i][8*k +: 8] = 8'hFB;
                w_c[i][k] = 1'b1;
            end else if (restart && k > 4) begin
                w_d[i][8*k +: 8] = 8'($urandom);
                w_c[i][k] = 1'b0;
            end else begin
                w_d[i][8*k +: 8] = 8'h07;
                w_c[i][k] = 1'b1;
            end
        end
        w_start[i] = restart;
        open[i] = restart;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NP; i++) put_idle(i);
    endtask

    task automatic data_all();
        for (int i = 0; i < NP; i++) put_data(i);
    endtask

    // Present one cycle of stimulus, predict the registered result, then advance to just after the next edge.
    task automatic step(input bit wr, input int port, input int src);
        exp_t e;
        for (int i = 0; i < NP; i++) begin
            rx_d[64*i +: 64] = w_d[i];
            rx_c[8*i +: 8]   = w_c[i];
        end
        cfg_wr   = wr;
        cfg_port = SW'(port);
        cfg_src  = SW'(src);
        for (int o = 0; o < NP; o++) begin
            if (m_pend[o] && !m_inf[m_act[o]] && !w_start[m_act[o]] && !m_inf[m_psrc[o]]) begin
                m_act[o]  = m_psrc[o];
                m_pend[o] = 1'b0;
            end
        end
        if (wr && port < NP && src < NP) begin
            if (src == m_act[port]) begin
                m_pend[port] = 1'b0;
            end else begin
                m_psrc[port] = src;
                m_pend[port] = 1'b1;
            end
        end
        for (int o = 0; o < NP; o++) begin
            e.d[64*o +: 64]  = w_d[m_act[o]];
            e.c[8*o +: 8]    = w_c[m_act[o]];
            e.sel[SW*o +: SW] = SW'(m_act[o]);
            e.pend[o]        = m_pend[o];
        end
        for (int i = 0; i < NP; i++) m_inf[i] = open[i];
        sbq.push_back(e);
        @(posedge clk);
        #2;
        cfg_wr = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NP; i++) begin
            m_act[i]  = reset_map[i];
            m_psrc[i] = 0;
            m_pend[i] = 1'b0;
            m_inf[i]  = 1'b0;
            rem[i]    = 0;
        end
        idle_all();
    endtask

    task automatic check_reset_state(input string tag);
        logic [NP*SW-1:0] m;
        for (int o = 0; o < NP; o++) m[SW*o +: SW] = SW'(reset_map[o]);
        chk({tag, "_tx_d"}, 256'(tx_d), 256'({NP{64'h0707_0707_0707_0707}}));
        chk({tag, "_tx_c"}, 256'(tx_c), 256'({NP{8'hFF}}));
        chk({tag, "_sel_active"}, 256'(sel_active), 256'(m));
        chk({tag, "_sel_pending"}, 256'(sel_pending), 256'(0));
    endtask

    // Asynchronous reset asserted between edges; outputs must go idle before any clock.
    task automatic do_reset(input string tag);
        sbq.delete();
        model_reset();
        for (int i = 0; i < NP; i++) begin
            rx_d[64*i +: 64] = w_d[i];
            rx_c[8*i +: 8]   = w_c[i];
        end
        rst_n = 1'b0;
        #1;
        check_reset_state(tag);
        repeat (2) @(posedge clk);
        #2;
        check_reset_state({tag, "_held"});
        rst_n = 1'b1;
    endtask

    task automatic gen_port(input int i);
        if (!open[i]) begin
            if ($urandom_range(3) == 0) begin
                put_start(i, 1'($urandom_range(1)));
                rem[i] = ($urandom_range(15) == 0) ? 30 : $urandom_range(1, 8);
            end else begin
                put_idle(i);
            end
        end else if (rem[i] > 0) begin
            put_data(i);
            rem[i]--;
        end else begin
            int lane;
            bit rs;
            lane = $urandom_range(7);
            rs = (lane <= 3) && ($urandom_range(2) == 0);
            put_term(i, lane, rs);
            if (rs) rem[i] = $urandom_range(1, 6);
        end
    endtask

    // Monitor: every cycle with a prediction outstanding, compare the registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("tx_d", 256'(tx_d), 256'(e.d));
                chk("tx_c", 256'(tx_c), 256'(e.c));
                chk("sel_active", 256'(sel_active), 256'(e.sel));
                chk("sel_pending", 256'(sel_pending), 256'(e.pend));
            end
        end
    end

    initial begin
        cfg_wr = 1'b0;
        cfg_port = '0;
        cfg_src = '0;
        rx_d = '0;
        rx_c = '0;
        rst_n = 1'b1;
        for (int i = 0; i < NP; i++) open[i] = 1'b0;
        #2;
        do_reset("por");

        // Default loopback carries rx0/rx1 frames.
        idle_all(); step(0, 0, 0);
        put_start(0, 0); put_start(1, 1); step(0, 0, 0);
        repeat (6) begin put_data(0); put_data(1); step(0, 0, 0); end
        put_term(0, 3, 0); put_term(1, 5, 0); step(0, 0, 0);
        idle_all(); step(0, 0, 0); step(0, 0, 0);

        // Request 2<-3 while rx0 is mid-frame; switch waits for rx0 idle.
        put_start(0, 0); step(0, 0, 0);
        put_data(0); step(1, 2, 3);
        repeat (3) begin put_data(0); step(0, 0, 0); end
        put_term(0, 7, 0); step(0, 0, 0);
        idle_all(); step(0, 0, 0); step(0, 0, 0);

        // Move 2 back to rx0, then request 2<-3 so the switch lands on rx3's Start word.
        step(1, 2, 0); step(0, 0, 0);
        put_start(0, 0); step(0, 0, 0);
        put_data(0); step(1, 2, 3);
        put_data(0); step(0, 0, 0);
        put_term(0, 1, 0); step(0, 0, 0);
        put_idle(0); put_start(3, 0); step(0, 0, 0);
        repeat (3) begin put_data(3); step(0, 0, 0); end
        put_term(3, 4, 0); step(0, 0, 0);
        idle_all(); step(0, 0, 0); step(0, 0, 0);

        // Back-to-back frames on rx0 keep pending 1<-2 waiting.
        put_start(0, 0); step(1, 1, 2);
        repeat (2) begin put_data(0); step(0, 0, 0); end
        put_term(0, 2, 1); step(0, 0, 0);
        repeat (2) begin put_data(0); step(0, 0, 0); end
        put_term(0, 6, 0); step(0, 0, 0);
        idle_all(); step(0, 0, 0); step(0, 0, 0);

        // Rewrite to the active source cancels the request; out-of-range writes do nothing.
        put_start(1, 0); step(0, 0, 0);
        put_data(1); step(1, 0, 2);
        put_data(1); step(1, 0, 1);
        put_data(1); step(0, 0, 0);
        put_term(1, 0, 0); step(0, 0, 0);
        idle_all(); step(1, 5, 0);
        step(1, 0, 6);
        step(1, 7, 7);
        step(0, 0, 0);

        // Reset mid-frame with a request outstanding.
        for (int i = 0; i < NP; i++) put_start(i, 0);
        step(0, 0, 0);
        data_all(); step(1, 0, 3);
        data_all(); step(0, 0, 0);
        do_reset("midframe");

        // Randomised traffic and configuration.
        for (int n = 0; n < 3000; n++) begin
            bit wr;
            for (int i = 0; i < NP; i++) gen_port(i);
            wr = ($urandom_range(5) == 0);
            step(wr, $urandom_range(7), $urandom_range(7));
        end
        idle_all();
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 256'(sbq.size()), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xgmii_xbar.md
Name: xgmii_xbar

Overview:
- Parametrised XGMII crossbar for the 10GBASE-R tap datapath, clocked on clk156 between network_path RX outputs and TX inputs.
- Each output port (TX) is driven from a run-time selectable input port (RX).
- Source changes are applied only on inter-frame idle boundaries, so no frame is ever truncated or spliced.
- Reset mapping comes from a parameter; the default reproduces the current fixed loopback (0<-1, 1<-0, 2<-0, 3<-1).

Parameters:
- NPORT, 4, number of XGMII ports (2..8).
- SEL_W, 2, select field width; 2**SEL_W >= NPORT.
- DEFAULT_MAP, 8'h41, packed {sel[NPORT-1],...,sel[0]} reset mapping, SEL_W bits per output.

Ports:
- clk156  in  1  156.25 MHz XGMII clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- rx_d  in  NPORT*64  input XGMII data; port i = bits [64i+63:64i].
- rx_c  in  NPORT*8  input XGMII control; port i = bits [8i+7:8i].
- tx_d  out  NPORT*64  output XGMII data, registered.
- tx_c  out  NPORT*8  output XGMII control, registered.
- cfg_wr  in  1  single-cycle mapping write strobe.
- cfg_port  in  SEL_W  output port being written.
- cfg_src  in  SEL_W  requested source port.
- sel_active  out  NPORT*SEL_W  currently applied mapping.
- sel_pending  out  NPORT  per-output flag: change requested, not yet applied.

Behaviour:
- Reset (async assert, sync deassert):
  - tx_d = 64'h0707_0707_0707_0707 per port; tx_c = 8'hFF per port.
  - sel_active = DEFAULT_MAP; sel_pending = 0; all frame trackers = 0.
- Lane k of port i is control char X when rx_c[8i+k]=1 and byte k equals X. Start = 8'hFB, valid only in lane 0 or 4. Terminate = 8'hFD, any lane.
- Per-input frame tracker in_frame[i], updated every cycle:
  - Set on Start.
  - Cleared on Terminate with no later-lane Start.
  - Terminate in lanes 0-3 followed by Start in lane 4: stays 1.
  - Start and Terminate both absent: holds.
- Datapath: tx port o at cycle t+1 = rx port sel_active[o] at cycle t. Latency is exactly 1 cycle and all ports are aligned. One input may feed any number of outputs.
- Per-output pending register: pend_src[o] plus sel_pending[o].
  - cfg_wr with cfg_port < NPORT and cfg_src < NPORT: if cfg_src == sel_active[cfg_port], pending is cleared; otherwise pend_src = cfg_src and pending is set. A later write overwrites an earlier pending value.
  - cfg_wr with cfg_port >= NPORT or cfg_src >= NPORT is ignored entirely.
- Switch condition for output o in cycle t (all must hold, evaluated on pre-write registered state):
  - sel_pending[o] = 1.
  - Current source has in_frame = 0 and no Start in its cycle-t word.
  - Requested source has in_frame = 0. A Start in its cycle-t word is allowed, so the frame is forwarded from its first word.
- When the condition holds: sel_active[o] <= pend_src[o], sel_pending[o] <= 0, and tx at t+1 is taken from the new source. There is no idle insertion and no dropped word.
- Same-cycle cfg_wr to output o while its switch fires: the switch completes first, then the write is evaluated against the new sel_active (it sets pending or clears it).
- Outputs are independent; any subset may switch in the same cycle.
- A source that never goes idle keeps its switch pending indefinitely; the old mapping keeps forwarding with no timeout.
- Reset mid-frame: tx is forced to idle immediately on assertion, and the trackers clear.

Test Plan:
- Reset, then drive idle on all ports and a 64B frame on rx0 and rx1 -> tx1/tx2 carry the rx0 frame and tx0/tx3 carry the rx1 frame, 1-cycle delayed, sel_active = 8'h41.
- cfg_wr port 2 src 3 while rx0 is mid-frame -> sel_pending[2]=1 and tx2 finishes the rx0 frame intact. Switch lands in the first cycle where rx0 is idle and rx3 is not mid-frame; sel_active[5:4]=2'd3.
- rx3 Start word in the same cycle rx0 is idle with pending 2<-3 -> tx2 shows the FB word at t+1 and the full rx3 frame follows.
- Back-to-back frames on rx0 (Terminate lane 2, Start lane 4 in one word) with pending 1<-2 -> no switch on that word; the switch occurs only after the second frame terminates.
- cfg_wr port 0 src 1 (equals active) after a pending write of src 2 -> sel_pending[0]=0 and the mapping stays unchanged. cfg_port=5 with NPORT=4 -> no effect.
- Assert sys_rst_n low mid-frame with pending set -> tx = 0707…/FF in the same cycle, sel_active=8'h41, sel_pending=0.
